integrate_dump_3p: RTL and testbench

- Integrate-and-dump stage placed directly downstream of the 4-stage pipelined 29-bit adder.
- Accepts the adder's sum word together with a valid strobe issued at the adder's input time.
- Delays that strobe internally to match the adder latency.
- Accumulates 2**N_LOG2 aligned, signed sums, then dumps the total with a one-cycle strobe; used for decimation and averaging in the filter chain.

---
 rtl/integrate_dump_3p_pkg.sv | 29 ++
 rtl/integrate_dump_3p_valid_delay.sv | 45 ++++
 rtl/integrate_dump_3p.sv | 95 +++++++++
 tb/tb_integrate_dump_3p.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/integrate_dump_3p_pkg.sv
// Shared definitions for integrate_dump_3p and the pipelined arithmetic stages
// around it: adder-matching defaults, output width rule, sign extension helper.
package integrate_dump_3p_pkg;

    // Defaults kept identical to the upstream 4-stage 29-bit adder
    localparam int unsigned WIDTH_DEF   = 29;
    localparam int unsigned LATENCY_DEF = 4;
    localparam int unsigned N_LOG2_DEF  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // Accumulator width that holds 2**n worst-case w-bit samples without overflow
    function automatic int unsigned owidth_rule(input int unsigned w, input int unsigned n);
        return w + n;
    endfunction

    // Sign-extend the low w bits of v to the full 64-bit word
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int unsigned w);
        logic [63:0] hi_mask;
        logic        sgn;
        hi_mask = ~((64'd1 << w) - 64'd1);
        sgn     = |(v & (64'd1 << (w - 1)));
        return sgn ? ((v & ~hi_mask) | hi_mask) : (v & ~hi_mask);
    endfunction

endpackage

// File: rtl/integrate_dump_3p_valid_delay.sv
// valid_delay: DEPTH-deep shift register for a valid strobe with synchronous
// flush. q is the last tap; any is high when any stage holds a set bit.
module valid_delay
    import integrate_dump_3p_pkg::*;
#(
    parameter int unsigned DEPTH = LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic d,
    output logic q,
    output logic any
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            // Single-stage delay: flush discards the incoming strobe too
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    sr <= '0;
                else if (flush)
                    sr <= '0;
                else
                    sr[0] <= d;
            end
        end else begin : g_multi
            // Shift the strobe one stage per clock; flush empties every stage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    sr <= '0;
                else if (flush)
                    sr <= '0;
                else
                    sr <= {sr[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q   = sr[DEPTH-1];
    assign any = |sr;

endmodule

// File: rtl/integrate_dump_3p.sv
// integrate_dump_3p: integrate-and-dump stage behind the pipelined adder.
// Aligns valid_in to the adder latency, accumulates 2**N_LOG2 signed sums and
// dumps the total with a one-cycle dump_valid strobe.
// Build option: define INTDUMP_AVG_EN to dump the rounded block average
// (total + 2**(N_LOG2-1)) >>> N_LOG2 instead of the raw total.
module integrate_dump_3p
    import integrate_dump_3p_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned N_LOG2  = N_LOG2_DEF,
    parameter int unsigned OWIDTH  = owidth_rule(WIDTH, N_LOG2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  sum_in,
    input  logic              clr,
    output logic [OWIDTH-1:0] acc_out,
    output logic              dump_valid,
    output logic              busy
);

    logic              v_al;
    logic              dl_any;
    logic [N_LOG2-1:0] cnt;
    logic [OWIDTH-1:0] acc;
    logic [OWIDTH-1:0] ext;
    logic [OWIDTH-1:0] total;
    logic [OWIDTH-1:0] dump_val;
    state_t            state;

    valid_delay #(
        .DEPTH (LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .flush (clr),
        .d     (valid_in),
        .q     (v_al),
        .any   (dl_any)
    );

    assign ext   = OWIDTH'(sign_ext(64'(sum_in), WIDTH));
    assign total = acc + ext;

`ifdef INTDUMP_AVG_EN
    localparam logic [OWIDTH:0] RND = (OWIDTH + 1)'(1) << (N_LOG2 - 1);
    logic signed [OWIDTH:0] rnd_sum;

    // Round half-up, then arithmetic shift down to the block average
    always_comb begin
        rnd_sum  = $signed({total[OWIDTH-1], total}) + $signed(RND);
        dump_val = OWIDTH'(rnd_sum >>> N_LOG2);
    end
`else
    // Raw block total is dumped as-is
    always_comb begin
        dump_val = total;
    end
`endif

    // Sample counter, accumulator and dump register; clr outranks a terminal sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            acc_out    <= '0;
            dump_valid <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            if (clr) begin
                state <= S_IDLE;
                cnt   <= '0;
                acc   <= '0;
            end else if (v_al) begin
                if (state == S_ACC && cnt == '1) begin
                    acc_out    <= dump_val;
                    dump_valid <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                    state      <= S_IDLE;
                end else begin
                    acc   <= total;
                    cnt   <= cnt + 1'b1;
                    state <= S_ACC;
                end
            end
        end
    end

    assign busy = (cnt != '0) | dl_any;

endmodule

// File: tb/tb_integrate_dump_3p.sv
// Self-checking bench for integrate_dump_3p: models the upstream adder,
// predicts each block dump (value and arrival cycle) when stimulus is issued,
// and compares in a separate monitor whenever dump_valid is seen.
module tb_integrate_dump_3p;

    localparam int W   = 29;
    localparam int LAT = 4;
    localparam int NL  = 4;
    localparam int OW  = 33;
    localparam int NS  = 1 << NL;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          valid_in = 1'b0;
    logic          clr      = 1'b0;
    logic [W-1:0]  x        = '0;
    logic [W-1:0]  y        = '0;
    logic [W-1:0]  sum_in;
    logic [OW-1:0] acc_out;
    logic          dump_valid;
    logic          busy;

    logic [W-1:0]  pipe [LAT];
    int            cyc = 0;

    typedef struct {
        logic [OW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    longint        blk_sum = 0;
    int            blk_n = 0;
    logic [OW-1:0] last_dump = '0;

    integrate_dump_3p #(
        .WIDTH   (W),
        .LATENCY (LAT),
        .N_LOG2  (NL),
        .OWIDTH  (OW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .sum_in     (sum_in),
        .clr        (clr),
        .acc_out    (acc_out),
        .dump_valid (dump_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Upstream adder model: LATENCY register stages from operands to sum
    always @(posedge clk) begin
        pipe[0] <= x + y;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sum_in = pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] expect_of(input longint s);
`ifdef INTDUMP_AVG_EN
        longint t;
        longint q;
        t = s + NS / 2;
        q = t / NS;
        if (t < 0 && (t % NS) != 0) q = q - 1;
        return OW'(q);
`else
        return OW'(s);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_sample(input logic [W-1:0] v);
        exp_t e;
        blk_sum += longint'($signed(v));
        blk_n++;
        if (blk_n == NS) begin
            e.val = expect_of(blk_sum);
            e.cyc = cyc + LAT + 1;
            exp_q.push_back(e);
            last_dump = e.val;
            blk_sum = 0;
            blk_n = 0;
        end
    endtask

    task automatic model_clr();
        blk_sum = 0;
        blk_n = 0;
    endtask

    task automatic issue(input logic [W-1:0] v, input bit mdl);
        valid_in = 1'b1;
        x = W'($urandom);
        y = v - x;
        if (mdl) model_sample(v);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d dumps outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every dump_valid must match the next predicted dump
    always @(negedge clk) begin
        if (reset && dump_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dump: got dump_valid=1 acc_out=%h expected no dump", acc_out);
            end else begin
                e = exp_q.pop_front();
                check("dump_value", 64'(acc_out), 64'(e.val));
                check("dump_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        idle(3);
        check("reset_acc_out", 64'(acc_out), 64'd0);
        check("reset_dump_valid", 64'(dump_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        idle(2);

        // Unity sum
        for (int i = 0; i < NS; i++) issue(W'(1), 1'b1);
        check("busy_in_flight", 64'(busy), 64'd1);
        drain();
        check("busy_after_dump", 64'(busy), 64'd0);

        // Negative sum (-3 each)
        for (int i = 0; i < NS; i++) issue(29'h1FFFFFFD, 1'b1);
        drain();

        // Back-to-back blocks, sample k = k
        for (int k = 0; k < 2 * NS; k++) issue(W'(k), 1'b1);
        drain();

        // Gapped valid
        for (int i = 0; i < NS; i++) begin
            issue(W'(5), 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        drain();

        // clr in the cycle of the terminal aligned sample
        for (int i = 0; i < NS - 1; i++) issue(W'(2), 1'b1);
        issue(W'(2), 1'b0);
        idle(LAT - 1);
        clr = 1'b1;
        model_clr();
        idle(1);
        clr = 1'b0;
        idle(8);
        check("acc_hold_after_clr", 64'(acc_out), 64'(last_dump));
        check("busy_after_clr", 64'(busy), 64'd0);
        for (int i = 0; i < NS; i++) issue(W'(2), 1'b1);
        drain();

        // Asynchronous reset mid-block
        for (int i = 0; i < 7; i++) issue(W'(1), 1'b1);
        idle(LAT + 2);
        check("busy_mid_block", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_acc_out", 64'(acc_out), 64'd0);
        check("async_rst_dump_valid", 64'(dump_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        #2 reset = 1'b1;
        model_clr();
        @(negedge clk);
        for (int i = 0; i < NS; i++) issue(W'(1), 1'b1);
        drain();

        // Random full-range samples with random gaps
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NS; i++) begin
                issue(W'($urandom), 1'b1);
                idle(int'($urandom_range(0, 2)));
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
